// File: rtl/float_byte_assembler_pkg.sv
// Shared definitions for the byte-serial float assembler and the downstream float classifier:
// byte-slot mapping, drop counter limit and the one-hot float class encodings.
package float_byte_assembler_pkg;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef enum logic [4:0] {
        FC_ZERO      = 5'b00001,
        FC_NORMAL    = 5'b00010,
        FC_SUBNORMAL = 5'b00100,
        FC_INF       = 5'b01000,
        FC_NAN       = 5'b10000
    } float_class_e;

    // Big endian keeps byte 0 in asm[23:16]; little endian keeps byte 0 in asm[7:0].
    function automatic logic [23:0] asm_store(input logic big_endian, input logic [1:0] slot,
                                              input logic [23:0] asm_q, input logic [7:0] b);
        logic [23:0] r;
        r = asm_q;
        if (big_endian) begin
            case (slot)
                2'd0:    r[23:16] = b;
                2'd1:    r[15:8]  = b;
                default: r[7:0]   = b;
            endcase
        end else begin
            case (slot)
                2'd0:    r[7:0]   = b;
                2'd1:    r[15:8]  = b;
                default: r[23:16] = b;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] word_join(input logic big_endian, input logic [23:0] asm_q,
                                              input logic [7:0] b);
        return big_endian ? {asm_q, b} : {b, asm_q};
    endfunction

    function automatic logic [7:0] drop_inc(input logic [7:0] cnt);
        return (cnt == DROP_MAX) ? DROP_MAX : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/float_byte_assembler_timer.sv
// Inter-byte idle counter; expired pulses on the cycle whose edge would bring the count to TIMEOUT.
module byte_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic ENABLED = (TIMEOUT > 0);

    logic [CNT_W-1:0] idle;

    assign expired = ENABLED && run && (idle == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle <= '0;
        end else if (clear || expired) begin
            idle <= '0;
        end else if (run) begin
            idle <= idle + 1'b1;
        end
    end

endmodule

// File: rtl/float_byte_assembler.sv
// Collects four accepted bytes into a 32-bit float word behind a valid/ready output,
// recovering from broken frames via in_sof or an inter-byte timeout.
module float_byte_assembler
    import float_byte_assembler_pkg::*;
#(
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    output logic [31:0] num_out,
    output logic        num_valid,
    input  logic        num_ready,
    output logic [7:0]  drop_cnt,
    output logic        busy
);
    localparam logic BE = (BIG_ENDIAN != 0);

    logic [1:0]  idx, idx_nxt;
    logic [23:0] asm_q, asm_nxt;
    logic [31:0] out_nxt;
    logic        vld_nxt;
    logic [7:0]  drop_nxt;
    logic        accept;
    logic        expired;

    assign in_ready = !num_valid || num_ready;
    assign busy     = (idx != 2'd0);
    assign accept   = in_valid && in_ready;

    byte_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (busy && !accept),
        .clear   (accept),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            asm_q     <= '0;
            num_out   <= '0;
            num_valid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            idx       <= idx_nxt;
            asm_q     <= asm_nxt;
            num_out   <= out_nxt;
            num_valid <= vld_nxt;
            drop_cnt  <= drop_nxt;
        end
    end

    // An accepted byte always beats a timeout expiring in the same cycle.
    always_comb begin
        idx_nxt  = idx;
        asm_nxt  = asm_q;
        out_nxt  = num_out;
        vld_nxt  = num_valid && !num_ready;
        drop_nxt = drop_cnt;
        if (accept) begin
            if (in_sof) begin
                asm_nxt = asm_store(BE, 2'd0, asm_q, in_byte);
                idx_nxt = 2'd1;
                if (idx != 2'd0) begin
                    drop_nxt = drop_inc(drop_cnt);
                end
            end else if (idx == 2'd3) begin
                out_nxt = word_join(BE, asm_q, in_byte);
                vld_nxt = 1'b1;
                idx_nxt = 2'd0;
            end else begin
                asm_nxt = asm_store(BE, idx, asm_q, in_byte);
                idx_nxt = idx + 2'd1;
            end
        end else if (expired) begin
            idx_nxt  = 2'd0;
            drop_nxt = drop_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_float_byte_assembler.sv
// Directed bench for float_byte_assembler: big- and little-endian instances, scoreboard on the output handshake.
module tb_float_byte_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [31:0] num_out;
    logic        num_valid;
    logic        num_ready;
    logic [7:0]  drop_cnt;
    logic        busy;

    logic [7:0]  le_in_byte;
    logic        le_in_valid;
    logic        le_in_sof;
    logic        le_in_ready;
    logic [31:0] le_num_out;
    logic        le_num_valid;
    logic        le_num_ready;
    logic [7:0]  le_drop_cnt;
    logic        le_busy;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    float_byte_assembler #(.BIG_ENDIAN(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .num_out(num_out), .num_valid(num_valid), .num_ready(num_ready),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    float_byte_assembler #(.BIG_ENDIAN(0), .TIMEOUT(16)) dut_le (
        .clk(clk), .rst_n(rst_n), .in_byte(le_in_byte), .in_valid(le_in_valid), .in_sof(le_in_sof),
        .in_ready(le_in_ready), .num_out(le_num_out), .num_valid(le_num_valid), .num_ready(le_num_ready),
        .drop_cnt(le_drop_cnt), .busy(le_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output handshake monitor: every transferred word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && num_valid && num_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $error("FAIL sb_unexpected: observed %h expected none", num_out);
            end else begin
                check("sb_word", num_out, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic sof);
        in_valid = 1'b1;
        in_byte  = b;
        in_sof   = sof;
        cyc();
        in_sof   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic send_word(input logic [31:0] w, input string tag);
        sb.push_back(w);
        for (int k = 0; k < 4; k++) drive(w[31-8*k -: 8], 1'b0);
        check({tag, "_valid"}, {31'd0, num_valid}, 32'd1);
        check({tag, "_out"}, num_out, w);
    endtask

    initial begin
        logic [7:0] le_bytes [4];
        le_bytes = '{8'h00, 8'h00, 8'h80, 8'h7F};
        rst_n = 1'b0;
        in_byte = 8'h00; in_valid = 1'b0; in_sof = 1'b0; num_ready = 1'b1;
        le_in_byte = 8'h00; le_in_valid = 1'b0; le_in_sof = 1'b0; le_num_ready = 1'b1;
        #2;
        check("rst_num_valid", {31'd0, num_valid}, 32'd0);
        check("rst_num_out", num_out, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Big-endian word, valid for exactly one cycle
        send_word(32'h3F800000, "be_word");
        idle_cycles(1);
        check("be_one_cycle", {31'd0, num_valid}, 32'd0);
        check("be_drop", {24'd0, drop_cnt}, 32'd0);

        // Backpressure
        num_ready = 1'b0;
        sb.push_back(32'h7F800000);
        drive(8'h7F, 1'b0); drive(8'h80, 1'b0); drive(8'h00, 1'b0); drive(8'h00, 1'b0);
        in_valid = 1'b1; in_byte = 8'hFF;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_stable", num_out, 32'h7F800000);
            cyc();
        end
        num_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(32'hFF800001);
        sb.push_back(32'h00000001);
        cyc();
        drive(8'h80, 1'b0); drive(8'h00, 1'b0); drive(8'h01, 1'b0);
        check("bp_word2", num_out, 32'hFF800001);
        drive(8'h00, 1'b0); drive(8'h00, 1'b0); drive(8'h00, 1'b0); drive(8'h01, 1'b0);
        check("bp_word3", num_out, 32'h00000001);
        idle_cycles(1);
        check("bp_drop", {24'd0, drop_cnt}, 32'd0);

        // Start-of-float mid-word
        drive(8'h7F, 1'b0); drive(8'h80, 1'b0);
        check("sof_busy", {31'd0, busy}, 32'd1);
        sb.push_back(32'h00000001);
        drive(8'h00, 1'b1); drive(8'h00, 1'b0); drive(8'h00, 1'b0); drive(8'h01, 1'b0);
        check("sof_out", num_out, 32'h00000001);
        check("sof_drop", {24'd0, drop_cnt}, 32'd1);
        idle_cycles(1);

        // Timeout after 16 idle cycles
        drive(8'hFF, 1'b0);
        idle_cycles(15);
        check("to15_busy", {31'd0, busy}, 32'd1);
        idle_cycles(1);
        check("to16_busy", {31'd0, busy}, 32'd0);
        check("to16_drop", {24'd0, drop_cnt}, 32'd2);
        sb.push_back(32'h7F800000);
        drive(8'h7F, 1'b1); drive(8'h80, 1'b0); drive(8'h00, 1'b0); drive(8'h00, 1'b0);
        check("to_word", num_out, 32'h7F800000);
        check("sof_idle_nodrop", {24'd0, drop_cnt}, 32'd2);
        idle_cycles(1);
        // 15 idle cycles is not a timeout
        sb.push_back(32'hFF800000);
        drive(8'hFF, 1'b0);
        idle_cycles(15);
        drive(8'h80, 1'b0); drive(8'h00, 1'b0); drive(8'h00, 1'b0);
        check("nto_word", num_out, 32'hFF800000);
        check("nto_drop", {24'd0, drop_cnt}, 32'd2);
        idle_cycles(1);

        // Little-endian instance
        for (int k = 0; k < 4; k++) begin
            le_in_valid = 1'b1;
            le_in_byte  = le_bytes[k];
            cyc();
        end
        le_in_valid = 1'b0;
        check("le_valid", {31'd0, le_num_valid}, 32'd1);
        check("le_out", le_num_out, 32'h7F800000);
        cyc();

        // Reset mid-word
        drive(8'h12, 1'b0); drive(8'h34, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_out", num_out, 32'd0);
        check("mrst_valid", {31'd0, num_valid}, 32'd0);
        check("mrst_drop", {24'd0, drop_cnt}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_le_out", le_num_out, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        send_word(32'h40490FDB, "post_rst");
        idle_cycles(1);
        check("post_rst_drop", {24'd0, drop_cnt}, 32'd0);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) drive(i[7:0], 1'b1);
        check("sat_drop", {24'd0, drop_cnt}, 32'hFF);
        check("sat_busy", {31'd0, busy}, 32'd1);
        idle_cycles(16);
        check("sat_to_busy", {31'd0, busy}, 32'd0);
        check("sat_to_drop", {24'd0, drop_cnt}, 32'hFF);

        idle_cycles(2);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
